mac_unit: RTL and testbench
===========================

// Module: mac_unit
// PURPOSE
//   Sequential unsigned multiply(-accumulate) unit for the accelerator datapath.
//   A one-cycle start pulse captures operands a and b. A radix-2 shift-add
//   multiplier then runs for DATA_WIDTH cycles. On completion, result is updated
//   and done pulses for one cycle. result holds its value until the next
//   operation completes.
// PARAMETERS
//   DATA_WIDTH  8   operand width (a, b), unsigned; >= 2
//   ACC_WIDTH   16  result/accumulator width; products wrap modulo 2**ACC_WIDTH
// PORTS
//   clk     in   1           single clock; all state changes on its rising edge
//   rst     in   1           asynchronous, active-high reset
//   a       in   DATA_WIDTH  multiplicand; sampled on the edge where start=1
//   b       in   DATA_WIDTH  multiplier; sampled on the edge where start=1
//   start   in   1           begin operation (level sampled; accepted only in IDLE)
//   result  out  ACC_WIDTH   registered product (or accumulated sum)
//   done    out  1           one-cycle completion pulse, registered
// BEHAVIOUR
//   Reset: state=IDLE; result=0; done=0; internal product/count=0. Reset takes
//     effect immediately and aborts any operation in progress; no done is issued.
//   FSM states:
//     IDLE: start=1 at an edge -> latch a and b, clear the partial product,
//       count=0, go to BUSY.
//     BUSY: each edge, if mcand bit[count]=1, partial += mplier << count
//       (computed at 2*DATA_WIDTH bits); count++.
//       On the edge where count==DATA_WIDTH-1, go to DONE.
//     DONE: one edge. result <= new value; done <= 1; go to IDLE.
//       done returns to 0 on the next edge.
//   Latency: start accepted at edge N -> result and done valid after edge
//     N+DATA_WIDTH+1 (N+9 at default parameters).
//   Start handling: start while BUSY or DONE is ignored; no queuing.
//     start held high re-triggers on the first IDLE edge after done.
//   Width: the full product is 2*DATA_WIDTH bits. It is zero-extended or
//     truncated (LSBs kept) to ACC_WIDTH. No saturation; overflow wraps silently.
//   result does not change during BUSY; it keeps the previous value.
//   Operands a=0 or b=0 still take the full latency and produce result=0.
// CONFIGURATION
//   MAC_ACCUMULATE_EN (macro):
//     Defined:
//       - Adds input port 'acc' (1 bit), sampled with start.
//       - acc=1: DONE writes result <= result + product (mod 2**ACC_WIDTH).
//       - acc=0: DONE writes result <= product.
//     Undefined:
//       - No 'acc' port.
//       - Every operation overwrites: result <= product (pure multiply).
// TESTING
//   1) rst=1 then release; a=3, b=4, start pulse 1 cycle
//        -> done pulses once 9 edges later, result=12.
//   2) After (1): a=5, b=6, start pulse
//        -> result=30 (not 42); done low between ops; result=12 until done.
//   3) a=255, b=255 -> result=65025; a=0, b=200 -> result=0 with full latency.
//   4) start pulsed again 3 cycles after the first accepted start
//        -> ignored; exactly one done; result matches the first operands.
//   5) Assert rst 4 cycles into an operation
//        -> result=0, done=0 immediately; no done afterwards; a new op works.
//   6) MAC_ACCUMULATE_EN: (3*4, acc=0) then (5*6, acc=1)
//        -> result=12, then 42. 200*200 with acc=1 from 65000
//        -> (65000+40000) mod 65536 = 39464.

Source files
------------

// File: rtl/mac_unit.sv
// mac_unit: sequential unsigned radix-2 shift-add multiplier with optional accumulate.
//   A one-cycle start in IDLE latches a/b; the product is built over DATA_WIDTH
//   cycles and written to result in a final DONE cycle, with a one-cycle done pulse.
// Configuration macro: MAC_ACCUMULATE_EN adds the 'acc' input. When acc=1 the
//   product is added into result; otherwise result is overwritten.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   a, b   - multiplicand / multiplier, sampled when start is accepted
//   start  - begin operation (accepted only in IDLE)
//   acc    - (MAC_ACCUMULATE_EN only) accumulate select, sampled with start
//   result - registered product or accumulated sum, ACC_WIDTH bits
//   done   - registered one-cycle completion pulse
module mac_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  start,
`ifdef MAC_ACCUMULATE_EN
  input  logic                  acc,
`endif
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  done
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic [DATA_WIDTH-1:0] mcand_q,   mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q,  mplier_d;
  logic [PROD_W-1:0]     partial_q, partial_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic [ACC_WIDTH-1:0]  result_q,  result_d;
  logic                  done_q,    done_d;
  logic                  acc_q,     acc_d;
  logic                  acc_in;
  logic [ACC_WIDTH-1:0]  product;

`ifdef MAC_ACCUMULATE_EN
  assign acc_in = acc;
`else
  assign acc_in = 1'b0;
`endif

  // Full product zero-extended or truncated (LSBs kept) to the result width.
  assign product = ACC_WIDTH'(partial_q);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    count_d   = count_q;
    result_d  = result_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = a;
          mplier_d  = b;
          partial_d = '0;
          count_d   = '0;
          acc_d     = acc_in;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // One multiplicand bit per cycle, shifted multiplier added at full width.
        if (mcand_q[count_q]) begin
          partial_d = partial_q + (PROD_W'(mplier_q) << count_q);
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = acc_q ? (result_q + product) : product;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      count_q   <= count_d;
      result_q  <= result_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: randomized and directed checks of mac_unit against an
//   arithmetic reference (result = a*b, or result + a*b when accumulating,
//   modulo 2**ACC_WIDTH; done exactly DATA_WIDTH+1 edges after start).
module tb_mac_unit;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned LAT  = DW + 1;
`ifdef MAC_ACCUMULATE_EN
  localparam bit HAS_ACC = 1'b1;
`else
  localparam bit HAS_ACC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          start;
  logic          acc;
  logic [AW-1:0] result;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned model_result;

  mac_unit #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .start  (start),
`ifdef MAC_ACCUMULATE_EN
    .acc    (acc),
`endif
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_result(input longint unsigned prev,
                                                 input longint unsigned x,
                                                 input longint unsigned y,
                                                 input bit accum);
    longint unsigned modulus = 64'd1 << AW;
    if (HAS_ACC && accum) return (prev + x * y) % modulus;
    return (x * y) % modulus;
  endfunction

  // Issue one operation; optionally re-pulse start mid-operation with other operands.
  task automatic do_op(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input bit accv, input bit repulse);
    longint unsigned exp;
    int lat;
    exp = ref_result(model_result, av, bv, accv);
    a = av; b = bv; acc = accv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = DW'($urandom); b = DW'($urandom); acc = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (repulse && i == 2) begin
        start = 1'b1; a = DW'($urandom); b = DW'($urandom);
      end
      if (repulse && i == 3) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      chk("hold_result", result, model_result);
    end
    chk("latency", lat, LAT);
    chk("result", result, exp);
    model_result = exp;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_low", done, 1'b0);
      chk("result_stable", result, model_result);
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; start = 1'b0; acc = 1'b0;
    model_result = 0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed products and boundaries.
    do_op(8'd3, 8'd4, 1'b0, 1'b0);
    do_op(8'd5, 8'd6, 1'b0, 1'b0);
    do_op(8'd255, 8'd255, 1'b0, 1'b0);
    do_op(8'd0, 8'd200, 1'b0, 1'b0);
    do_op(8'd200, 8'd0, 1'b0, 1'b0);
    // Start re-pulsed while busy is ignored.
    do_op(8'd7, 8'd9, 1'b0, 1'b1);

    // Reset four cycles into an operation aborts it.
    a = 8'd11; b = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_result", result, 0);
    chk("abort_done", done, 1'b0);
    model_result = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 1'b0);
    end
    do_op(8'd17, 8'd19, 1'b0, 1'b0);

`ifdef MAC_ACCUMULATE_EN
    do_op(8'd3, 8'd4, 1'b0, 1'b0);
    do_op(8'd5, 8'd6, 1'b1, 1'b0);
    chk("acc_42", result, 42);
    do_op(8'd250, 8'd250, 1'b0, 1'b0);
    do_op(8'd50, 8'd50, 1'b1, 1'b0);
    chk("acc_65000", result, 65000);
    do_op(8'd200, 8'd200, 1'b1, 1'b0);
    chk("acc_wrap", result, 39464);
`endif

    // Randomized operations against the reference.
    for (int n = 0; n < 16; n++) begin
      do_op(DW'($urandom), DW'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
